// File: rtl/module_freq_meter.sv
// Frequency meter: counts rising edges of an asynchronous square wave
// over back-to-back gate windows timed from the system clock.
module module_freq_meter #(
    parameter int unsigned frequency   = 27_000_000,
    parameter int unsigned gate_cycles = 27_000_000,
    parameter int unsigned count_w     = 25
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sig_in,
    output logic [count_w-1:0] freq_hz,
    output logic               valid,
    output logic               ovf,
    output logic               no_signal
);

    localparam int unsigned GATE_W = $clog2(gate_cycles);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(gate_cycles - 1);
    localparam logic [count_w-1:0] CNT_MAX = '1;

    if (gate_cycles < 2 || frequency == 0) begin : g_bad_param
        $error("gate_cycles must be >= 2 and frequency nonzero");
    end

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         arm_q, arm_d;
    logic [GATE_W-1:0]  gate_q, gate_d;
    logic [count_w-1:0] edge_q, edge_d;
    logic               sat_q, sat_d;
    logic [count_w-1:0] freq_q, freq_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;
    logic               nosig_q, nosig_d;
    logic               s1_q, s2_q, s3_q;

    logic               rise;
    logic               at_max;
    logic               bump;
    logic [count_w-1:0] result;
    logic               res_sat;

    // Two-flop synchronizer plus history stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise    = s2_q & ~s3_q;
    assign at_max  = (edge_q == CNT_MAX);
    assign bump    = rise & ~at_max;
    assign result  = edge_q + {{(count_w-1){1'b0}}, bump};
    assign res_sat = sat_q | (rise & at_max);

    // State, counters and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            arm_q   <= '0;
            gate_q  <= '0;
            edge_q  <= '0;
            sat_q   <= 1'b0;
            freq_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            nosig_q <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm_d;
            gate_q  <= gate_d;
            edge_q  <= edge_d;
            sat_q   <= sat_d;
            freq_q  <= freq_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            nosig_q <= nosig_d;
        end
    end

    // Next-state: settle in ARM, then run continuous gate windows.
    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        gate_d  = gate_q;
        edge_d  = edge_q;
        sat_d   = sat_q;
        freq_d  = freq_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q;
        nosig_d = nosig_q;
        unique case (state_q)
            IDLE: begin
                arm_d  = '0;
                gate_d = '0;
                edge_d = '0;
                sat_d  = 1'b0;
                if (en) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (!en) begin
                    state_d = IDLE;
                    arm_d   = '0;
                end else if (arm_q == 2'd2) begin
                    state_d = MEASURE;
                    arm_d   = '0;
                end else begin
                    arm_d = arm_q + 2'd1;
                end
            end
            MEASURE: begin
                if (!en) begin
                    state_d = IDLE;
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                end else if (gate_q == GATE_LAST) begin
                    freq_d  = result;
                    ovf_d   = res_sat;
                    nosig_d = (result == '0);
                    valid_d = 1'b1;
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                end else begin
                    gate_d = gate_q + GATE_W'(1);
                    edge_d = result;
                    sat_d  = res_sat;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign freq_hz   = freq_q;
    assign valid     = valid_q;
    assign ovf       = ovf_q;
    assign no_signal = nosig_q;

endmodule

// File: tb/tb_module_freq_meter.sv
// Bench for module_freq_meter: table vectors, directed corner cases
// and random stimulus against a window-counting reference model.
module tb_module_freq_meter;

    localparam int G   = 100;
    localparam int CW  = 4;
    localparam int MAXC = 15;
    localparam int NS  = 30000;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          sig_in;
    logic [CW-1:0] freq_hz;
    logic          valid;
    logic          ovf;
    logic          no_signal;

    module_freq_meter #(
        .frequency  (27_000_000),
        .gate_cycles(G),
        .count_w    (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sig_in   (sig_in),
        .freq_hz  (freq_hz),
        .valid    (valid),
        .ovf      (ovf),
        .no_signal(no_signal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int lo;
        int f;
        int o;
        int n;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int rel = 0;
    int start = 0;
    bit running = 0;
    bit smp [0:NS-1];

    logic m_valid = 1'b0;
    int   m_freq = 0;
    logic m_ovf = 1'b0;
    logic m_nos = 1'b0;

    int p_hi = 5;
    int p_lo = 5;
    int ph = 0;

    int seen;
    int last_f;
    int last_o;
    int last_n;

    function automatic bit S(int j);
        if (j < rel || j < 0) return 1'b0;
        return smp[j];
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        running = 0;
        m_valid = 1'b0;
        m_freq  = 0;
        m_ovf   = 1'b0;
        m_nos   = 1'b0;
        rel     = cyc + 1;
    endtask

    // Reference: a window closes every G cycles once 3 settle cycles
    // after enable have passed; its result is the number of sampled
    // rising edges of sig_in seen through the 3-cycle input delay.
    task automatic model_edge();
        int cnt;
        if (cyc >= NS) begin
            $display("FAIL cycle_budget: got %0d expected < %0d", cyc, NS);
            $fatal(1);
        end
        if (rst) begin
            model_reset();
            return;
        end
        smp[cyc] = sig_in;
        m_valid = 1'b0;
        if (!running && en) begin
            running = 1;
            start   = cyc;
        end else if (running && !en) begin
            running = 0;
        end else if (running && (cyc - start) >= G + 3 &&
                     ((cyc - start - 3) % G) == 0) begin
            cnt = 0;
            for (int j = cyc - G + 1; j <= cyc; j++) begin
                if (S(j - 2) && !S(j - 3)) cnt++;
            end
            m_valid = 1'b1;
            m_freq  = (cnt > MAXC) ? MAXC : cnt;
            m_ovf   = (cnt > MAXC);
            m_nos   = (cnt == 0);
        end
    endtask

    task automatic tick(input logic en_v, input logic sig_v);
        en     = en_v;
        sig_in = sig_v;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check("valid", valid, m_valid);
        check("freq_hz", freq_hz, m_freq);
        check("ovf", ovf, m_ovf);
        check("no_signal", no_signal, m_nos);
        if (valid) begin
            seen++;
            last_f = freq_hz;
            last_o = ovf;
            last_n = no_signal;
        end
    endtask

    task automatic nxt(output logic s);
        if (p_hi == 0) begin
            s = 1'b0;
        end else begin
            s  = (ph < p_hi);
            ph = (ph + 1) % (p_hi + p_lo);
        end
    endtask

    task automatic run_pat(input int hi, input int lo, input int n);
        logic s;
        p_hi = hi;
        p_lo = lo;
        ph   = 0;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            nxt(s);
            tick(1'b1, s);
        end
    endtask

    task automatic wait_valid(input int maxn, output int n);
        logic s;
        n = -1;
        for (int i = 1; i <= maxn; i++) begin
            nxt(s);
            tick(1'b1, s);
            if (valid) begin
                n = i;
                break;
            end
        end
    endtask

    // Called at posedge+1: pulses rst for 3 ns between clock edges.
    task automatic async_rst_pulse(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, "_rst_freq"}, freq_hz, 0);
        check({tag, "_rst_valid"}, valid, 0);
        check({tag, "_rst_ovf"}, ovf, 0);
        check({tag, "_rst_nosig"}, no_signal, 0);
        model_reset();
        #2 rst = 1'b0;
    endtask

    initial begin
        vec_t tbl [8];
        int n;
        int k;
        int vcnt;
        logic s;

        tbl[0] = '{hi: 5,  lo: 5,  f: 10, o: 0, n: 0};
        tbl[1] = '{hi: 0,  lo: 0,  f: 0,  o: 0, n: 1};
        tbl[2] = '{hi: 1,  lo: 1,  f: 15, o: 1, n: 0};
        tbl[3] = '{hi: 5,  lo: 5,  f: 10, o: 0, n: 0};
        tbl[4] = '{hi: 2,  lo: 3,  f: 15, o: 1, n: 0};
        tbl[5] = '{hi: 25, lo: 25, f: 2,  o: 0, n: 0};
        tbl[6] = '{hi: 10, lo: 10, f: 5,  o: 0, n: 0};
        tbl[7] = '{hi: 3,  lo: 2,  f: 15, o: 1, n: 0};

        rst    = 1'b1;
        en     = 1'b1;
        sig_in = 1'b0;
        seen   = 0;
        #1;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        check("reset_freq", freq_hz, 0);
        check("reset_valid", valid, 0);
        check("reset_ovf", ovf, 0);
        check("reset_nosig", no_signal, 0);
        rst = 1'b0;

        // Period-10 input: first window after 1+3+100 cycles.
        p_hi = 5; p_lo = 5; ph = 0;
        wait_valid(200, n);
        check("t1_first_latency", n, 104);
        check("t1_first_freq", freq_hz, 10);
        wait_valid(150, n);
        check("t1_period", n, 100);
        check("t1_freq", freq_hz, 10);
        check("t1_ovf", ovf, 0);
        check("t1_nosig", no_signal, 0);

        // Table: steady patterns, last window result per entry.
        for (int i = 0; i < 8; i++) begin
            run_pat(tbl[i].hi, tbl[i].lo, 250);
            check("tbl_seen", (seen > 0) ? 1 : 0, 1);
            check("tbl_freq", last_f, tbl[i].f);
            check("tbl_ovf", last_o, tbl[i].o);
            check("tbl_nosig", last_n, tbl[i].n);
        end

        // en dropped at gate count 50, then re-armed.
        run_pat(5, 5, 250);
        wait_valid(150, n);
        check("t4_sync", (n > 0) ? 1 : 0, 1);
        for (int i = 0; i < 50; i++) begin
            nxt(s);
            tick(1'b1, s);
        end
        vcnt = 0;
        for (int i = 0; i < 30; i++) begin
            nxt(s);
            tick(1'b0, s);
            if (valid) vcnt++;
        end
        check("t4_no_valid", vcnt, 0);
        check("t4_hold_freq", freq_hz, 10);
        wait_valid(200, n);
        check("t4_rearm_latency", n, 104);
        check("t4_rearm_freq", freq_hz, 10);

        // Asynchronous reset mid-window at gate count 70.
        wait_valid(150, n);
        for (int i = 0; i < 70; i++) begin
            nxt(s);
            tick(1'b1, s);
        end
        async_rst_pulse("t5");
        wait_valid(200, n);
        check("t5_restart_latency", n, 104);
        check("t5_restart_freq", freq_hz, 10);

        // sig_in high through reset release, then period 20 with a
        // rise landing on the last gate cycle of every window.
        rst = 1'b1;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        rst = 1'b0;
        start = cyc + 1;
        k = start;
        for (int w = 0; w < 3; w++) begin
            n = -1;
            for (int i = 1; i <= 104; i++) begin
                if (k <= start + 5) s = 1'b1;
                else s = ((((k - start - 101) % 20) + 20) % 20) < 10;
                k++;
                tick(1'b1, s);
                if (valid) begin
                    n = i;
                    break;
                end
            end
            check("t6_latency", n, (w == 0) ? 104 : 100);
            check("t6_freq", freq_hz, 5);
            check("t6_ovf", ovf, 0);
            check("t6_nosig", no_signal, 0);
        end

        // Random segments against the reference model.
        for (int seg = 0; seg < 30; seg++) begin
            int mode;
            int len;
            mode = $urandom % 4;
            len  = $urandom_range(260, 40);
            p_hi = $urandom_range(8, 1);
            p_lo = $urandom_range(8, 1);
            ph   = 0;
            if (mode == 1) p_hi = 0;
            if (($urandom % 6) == 0) async_rst_pulse("rnd");
            for (int i = 0; i < len; i++) begin
                if (mode == 0) s = logic'($urandom % 2);
                else nxt(s);
                tick(($urandom % 150) != 0, s);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/module_freq_meter.md
Name: module_freq_meter

Overview:
- Frequency meter: the inverse of the team's frequency divider. It counts rising edges of an external square wave over a fixed gate window timed from the 27 MHz system clock.
- Reports the measured count (Hz when the gate is 1 s), a one-cycle valid strobe, an overflow flag and a no-signal flag.
- Sits beside the divider. Used to check divider outputs on the board, or to measure external sensor or oscillator inputs feeding the display path.

Parameters:
- frequency, 27_000_000, input clock frequency in Hz (documentation and default derivation only)
- gate_cycles, 27_000_000, gate window length in clk cycles; the default gives a 1 s window, so the count reads in Hz; minimum 2
- count_w, 25, width of the edge counter and result

Ports:
- clk  input  1  system clock, 27 MHz
- rst  input  1  asynchronous active-high reset
- en  input  1  measurement enable, synchronous to clk
- sig_in  input  1  asynchronous square wave to measure
- freq_hz  output  count_w  edge count of the last completed window
- valid  output  1  one-cycle strobe; freq_hz/ovf/no_signal just updated
- ovf  output  1  last window's edge count saturated
- no_signal  output  1  last window counted zero edges

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous, active-high. All state is cleared immediately on rst=1, independent of clk.
- Reset values: freq_hz=0, valid=0, ovf=0, no_signal=0, FSM=IDLE, gate counter=0, edge counter=0, all synchronizer stages=0.
- Input conditioning:
  - 2-FF synchronizer s1,s2, plus history register s3.
  - Rising edge detected when s2=1 and s3=0.
  - Latency from a sig_in rise to the counted edge is 3 clk cycles.
- FSM states: IDLE, ARM, MEASURE.
  - IDLE: edges ignored, counters held at 0. en=1 -> ARM next cycle.
  - ARM: exactly 3 cycles so the synchronizer settles. Edges ignored; s1..s3 keep shifting. Go to MEASURE after the 3rd cycle. en=0 -> IDLE.
  - MEASURE: gate counter runs 0..gate_cycles-1, and each detected edge increments the edge counter.
    - On the cycle gate counter == gate_cycles-1, the closing window's result = edge counter + (edge detected this cycle).
    - That result is registered into freq_hz on the next clk edge, with valid=1 for exactly that one cycle.
    - Gate and edge counters restart at 0 with no gap, so windows are back-to-back and continuous. There is no ARM between windows.
    - en=0 at any point in MEASURE -> IDLE next cycle. The partial window is discarded, no valid is produced, and freq_hz/ovf/no_signal hold their last values.
- Arithmetic: the edge counter saturates at 2^count_w-1 and never wraps. If any increment is attempted at saturation in a window, ovf=1 is latched with that window's result.
- Flags:
  - no_signal=1 when the registered result is 0.
  - ovf and no_signal are updated only together with freq_hz, on valid.
- Boundaries:
  - sig_in high at reset release or en rise: not counted, because ARM masks it. Only later rising edges count.
  - Edge on the last gate cycle: counted in the closing window.
  - Edge on the first cycle of the next window: counted in the new window.
  - rst mid-window: outputs clear asynchronously and no valid fires. After release, IDLE and ARM are repeated.
- Max measurable rate: clk/2, since sig_in must be high ≥1 clk and low ≥1 clk.

Test Plan:
1. gate_cycles=100, en=1 from reset, sig_in period 10 clk (5 high/5 low) -> first valid 104 cycles after reset release (1 IDLE + 3 ARM + 100 MEASURE), then every 100 cycles with freq_hz=10, ovf=0, no_signal=0.
2. gate_cycles=100, sig_in tied 0 -> valid every 100 cycles with freq_hz=0, no_signal=1, ovf=0.
3. gate_cycles=100, count_w=4, sig_in toggling every clk (50 edges/window) -> freq_hz=15, ovf=1 on each valid; then drop to period 10 -> the next full window gives freq_hz=10, ovf=0.
4. gate_cycles=100, period 10, en deasserted at gate count 50 -> no valid, and freq_hz keeps the prior value 10. en re-asserted -> 3 ARM cycles, then a full 100-cycle window and valid with freq_hz=10.
5. rst pulsed asynchronously (mid-cycle, 3 ns) at gate count 70 -> freq_hz, valid, ovf, no_signal all 0 before the next clk edge. Measurement restarts from IDLE after release.
6. sig_in held 1 through reset release, then period 20 clk, gate_cycles=100 -> the held-high level is not counted, and each window gives freq_hz=5 exactly, including a sig_in rise on gate count 99 being counted in the closing window.
